// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback source selects, mul/div sequencer
// state encoding and default mul/div latencies.
// Optional macro HAZARD_DIV_EN adds the DIV sequencer state.
package cpu_pkg;

  localparam logic [2:0] DIN_SEL_PC8   = 3'b001;
  localparam logic [2:0] DIN_SEL_DMOUT = 3'b010;
  localparam logic [2:0] DIN_SEL_CP0   = 3'b011;
  localparam logic [2:0] DIN_SEL_HI    = 3'b100;
  localparam logic [2:0] DIN_SEL_LO    = 3'b101;
  localparam logic [2:0] DIN_SEL_ALU   = 3'b110;

  localparam int unsigned MUL_LAT_DEF = 4;
  localparam int unsigned DIV_LAT_DEF = 32;

`ifdef HAZARD_DIV_EN
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;
`else
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DONE = 2'd3
  } md_state_t;
`endif

endpackage

// File: rtl/pipe_hazard_ctrl_md_seq.sv
// Mul/div latency sequencer: counts the unit's latency after a launch and
// emits a one-cycle HI/LO write strobe when the result is ready.
// Optional macro HAZARD_DIV_EN enables a separate divide latency.
module md_seq
  import cpu_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start_ex,
  input  logic md_op_ex,
  input  logic flush,
  output logic md_busy,
  output logic md_done,
  output logic hilo_we
);

`ifdef HAZARD_DIV_EN
  localparam int unsigned CNT_W = $clog2(DIV_LAT + 1);
`else
  localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);
  localparam int unsigned DIV_LAT_UNUSED = DIV_LAT;
  logic md_op_unused;
  assign md_op_unused = md_op_ex;
`endif

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next state and counter; a start while busy is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start_ex && !flush) begin
`ifdef HAZARD_DIV_EN
          if (md_op_ex) begin
            state_d = MD_DIV;
            cnt_d   = CNT_W'(DIV_LAT - 1);
          end else begin
            state_d = MD_MUL;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end
`else
          state_d = MD_MUL;
          cnt_d   = CNT_W'(MUL_LAT - 1);
`endif
        end
      end
`ifdef HAZARD_DIV_EN
      MD_MUL, MD_DIV: begin
`else
      MD_MUL: begin
`endif
        if (flush) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // The issuing instruction has retired, so a flush here still writes.
      MD_DONE: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != MD_IDLE);
    done_d = (state_d == MD_DONE);
  end

  // State, counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign md_busy = busy_q;
  assign md_done = done_q;
  assign hilo_we = done_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO stall detection plus the
// mul/div latency sequencer. Stalls are combinational, same-cycle.
// Optional macro HAZARD_DIV_EN enables a separate divide latency.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       r1_r_id,
  input  logic       r2_r_id,
  input  logic [4:0] r1_id,
  input  logic [4:0] r2_id,
  input  logic       hilo_r_id,
  input  logic       md_id,
  input  logic [2:0] din_sel_ex,
  input  logic [2:0] din_sel_mem,
  input  logic [4:0] rw_ex,
  input  logic [4:0] rw_mem,
  input  logic       md_start_ex,
  input  logic       md_op_ex,
  input  logic       flush,
  output logic       stall_pc,
  output logic       stall_ifid,
  output logic       bubble_idex,
  output logic       md_busy,
  output logic       md_done,
  output logic       hilo_we
);

  logic lu_ex_c;
  logic lu_mem_c;
  logic hh_c;
  logic stall_c;

  md_seq #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) u_md_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .md_start_ex(md_start_ex),
    .md_op_ex   (md_op_ex),
    .flush      (flush),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .hilo_we    (hilo_we)
  );

  // Hazard detection; loaded data is never forwarded, so a load producer
  // in EX or MEM that ID depends on must stall.
  always_comb begin
    lu_ex_c  = (din_sel_ex == DIN_SEL_DMOUT) && (rw_ex != 5'd0) &&
               ((r1_r_id && (r1_id == rw_ex)) || (r2_r_id && (r2_id == rw_ex)));
    lu_mem_c = (din_sel_mem == DIN_SEL_DMOUT) && (rw_mem != 5'd0) &&
               ((r1_r_id && (r1_id == rw_mem)) || (r2_r_id && (r2_id == rw_mem)));
    hh_c     = (hilo_r_id || md_id) && (md_busy || md_start_ex);
    stall_c  = (lu_ex_c || lu_mem_c || hh_c) && !flush && rst_n;
  end

  assign stall_pc    = stall_c;
  assign stall_ifid  = stall_c;
  assign bubble_idex = stall_c;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle hazard
// vectors plus hand-written multi-cycle mul/div, flush and reset sequences.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = 32;
`ifdef HAZARD_DIV_EN
  localparam int unsigned EXP_DIV = DIV_LAT;
`else
  localparam int unsigned EXP_DIV = MUL_LAT;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       r1_r_id, r2_r_id;
  logic [4:0] r1_id, r2_id;
  logic       hilo_r_id, md_id;
  logic [2:0] din_sel_ex, din_sel_mem;
  logic [4:0] rw_ex, rw_mem;
  logic       md_start_ex, md_op_ex, flush;
  logic       stall_pc, stall_ifid, bubble_idex;
  logic       md_busy, md_done, hilo_we;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic stall;
    logic busy;
    logic done;
  } exp_t;

  typedef struct {
    logic       r1_r;
    logic       r2_r;
    logic [4:0] r1;
    logic [4:0] r2;
    logic       hilo_r;
    logic       md;
    logic [2:0] dse;
    logic [2:0] dsm;
    logic [4:0] rwe;
    logic [4:0] rwm;
    logic       fl;
    logic       exp_stall;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[11];

  pipe_hazard_ctrl #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r1_r_id    (r1_r_id),
    .r2_r_id    (r2_r_id),
    .r1_id      (r1_id),
    .r2_id      (r2_id),
    .hilo_r_id  (hilo_r_id),
    .md_id      (md_id),
    .din_sel_ex (din_sel_ex),
    .din_sel_mem(din_sel_mem),
    .rw_ex      (rw_ex),
    .rw_mem     (rw_mem),
    .md_start_ex(md_start_ex),
    .md_op_ex   (md_op_ex),
    .flush      (flush),
    .stall_pc   (stall_pc),
    .stall_ifid (stall_ifid),
    .bubble_idex(bubble_idex),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .hilo_we    (hilo_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic idle_inputs();
    r1_r_id = 0; r2_r_id = 0; r1_id = 0; r2_id = 0;
    hilo_r_id = 0; md_id = 0; din_sel_ex = 0; din_sel_mem = 0;
    rw_ex = 0; rw_mem = 0; md_start_ex = 0; md_op_ex = 0; flush = 0;
  endtask

  // One cycle: expectation queued when stimulus is applied, compared at negedge.
  task automatic cyc(input string tag, input logic s, input logic b, input logic d);
    exp_t e;
    e.stall = s; e.busy = b; e.done = d;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, " stall_pc"}, stall_pc, e.stall);
    chk({tag, " stall_ifid"}, stall_ifid, e.stall);
    chk({tag, " bubble_idex"}, bubble_idex, e.stall);
    chk({tag, " md_busy"}, md_busy, e.busy);
    chk({tag, " md_done"}, md_done, e.done);
    chk({tag, " hilo_we"}, hilo_we, e.done);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          r1r r2r r1 r2 hilo md dse     dsm     rwe rwm fl exp
    vecs[0]  = '{1, 0, 5, 0, 0, 0, 3'b010, 3'b000, 5, 0, 0, 1}; // load in EX, rs
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 3'b010, 3'b000, 0, 0, 0, 0}; // rw_ex = $0
    vecs[2]  = '{0, 1, 0, 7, 0, 0, 3'b000, 3'b010, 0, 7, 0, 1}; // load in MEM, rt
    vecs[3]  = '{0, 0, 0, 7, 0, 0, 3'b000, 3'b010, 0, 7, 0, 0}; // rt not read
    vecs[4]  = '{1, 0, 5, 0, 0, 0, 3'b110, 3'b000, 5, 0, 0, 0}; // ALU producer
    vecs[5]  = '{1, 0, 5, 0, 0, 0, 3'b010, 3'b000, 6, 0, 0, 0}; // other reg
    vecs[6]  = '{1, 0, 5, 0, 0, 0, 3'b010, 3'b000, 5, 0, 1, 0}; // flush wins
    vecs[7]  = '{0, 0, 0, 0, 1, 0, 3'b000, 3'b000, 0, 0, 0, 0}; // mfhi, unit idle
    vecs[8]  = '{0, 0, 0, 0, 0, 1, 3'b000, 3'b000, 0, 0, 0, 0}; // mult, unit idle
    vecs[9]  = '{1, 1, 9, 9, 0, 0, 3'b010, 3'b000, 9, 0, 0, 1}; // both sources
    vecs[10] = '{1, 0, 0, 0, 0, 0, 3'b000, 3'b010, 0, 0, 0, 0}; // MEM rw = $0

    idle_inputs();
    rst_n = 0;
    // Reset: a load-use hazard present still yields no stall.
    r1_r_id = 1; r1_id = 5; din_sel_ex = 3'b010; rw_ex = 5;
    #3;
    chk("rst stall_pc", stall_pc, 1'b0);
    chk("rst bubble_idex", bubble_idex, 1'b0);
    chk("rst md_busy", md_busy, 1'b0);
    chk("rst md_done", md_done, 1'b0);
    chk("rst hilo_we", hilo_we, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1;

    // Table of single-cycle hazard vectors, unit idle.
    for (int i = 0; i < 11; i++) begin
      r1_r_id = vecs[i].r1_r; r2_r_id = vecs[i].r2_r;
      r1_id = vecs[i].r1; r2_id = vecs[i].r2;
      hilo_r_id = vecs[i].hilo_r; md_id = vecs[i].md;
      din_sel_ex = vecs[i].dse; din_sel_mem = vecs[i].dsm;
      rw_ex = vecs[i].rwe; rw_mem = vecs[i].rwm; flush = vecs[i].fl;
      cyc($sformatf("vec%0d", i), vecs[i].exp_stall, 1'b0, 1'b0);
    end
    idle_inputs();

    // lw $5 in EX then MEM (bubble in EX), ID add held: two stalls, then go.
    r1_r_id = 1; r1_id = 5; din_sel_ex = 3'b010; rw_ex = 5;
    cyc("lu c1", 1, 0, 0);
    din_sel_ex = 0; rw_ex = 0; din_sel_mem = 3'b010; rw_mem = 5;
    cyc("lu c2", 1, 0, 0);
    din_sel_mem = 3'b110;
    cyc("lu c3", 0, 0, 0);
    idle_inputs();

    // mult at T with mfhi in ID from T.
    hilo_r_id = 1; md_start_ex = 1;
    cyc("mul T", 1, 0, 0);
    md_start_ex = 0;
    for (int i = 1; i <= MUL_LAT; i++) cyc($sformatf("mul T+%0d", i), 1, 1, 0);
    cyc("mul done", 1, 1, 1);
    cyc("mul go", 0, 0, 0);
    idle_inputs();

    // Divide (or multiply latency when the divide option is absent).
    md_start_ex = 1; md_op_ex = 1;
    cyc("div T", 0, 0, 0);
    md_start_ex = 0; md_op_ex = 0;
    for (int i = 1; i <= EXP_DIV; i++) cyc($sformatf("div T+%0d", i), 0, 1, 0);
    cyc("div done", 0, 1, 1);
    cyc("div idle", 0, 0, 0);

    // Flush mid-operation: stall drops with flush, no write follows.
    md_id = 1; md_start_ex = 1;
    cyc("fl T", 1, 0, 0);
    md_start_ex = 0;
    cyc("fl T+1", 1, 1, 0);
    flush = 1;
    cyc("fl T+2", 0, 1, 0);
    flush = 0;
    for (int i = 3; i < 3 + MUL_LAT + 2; i++) cyc($sformatf("fl T+%0d", i), 0, 0, 0);
    idle_inputs();

    // Load-use coincident with a busy HI/LO hazard: no extra cycles.
    md_start_ex = 1;
    cyc("cmb T", 0, 0, 0);
    md_start_ex = 0; hilo_r_id = 1;
    r1_r_id = 1; r1_id = 3; din_sel_ex = 3'b010; rw_ex = 3;
    cyc("cmb T+1", 1, 1, 0);
    cyc("cmb T+2", 1, 1, 0);
    din_sel_ex = 0; rw_ex = 0;
    for (int i = 3; i <= MUL_LAT; i++) cyc($sformatf("cmb T+%0d", i), 1, 1, 0);
    cyc("cmb done", 1, 1, 1);
    cyc("cmb go", 0, 0, 0);
    idle_inputs();

    // Flush in the DONE cycle does not suppress the write.
    md_start_ex = 1;
    cyc("fd T", 0, 0, 0);
    md_start_ex = 0;
    for (int i = 1; i <= MUL_LAT; i++) cyc($sformatf("fd T+%0d", i), 0, 1, 0);
    flush = 1;
    cyc("fd done", 0, 1, 1);
    flush = 0;
    cyc("fd idle", 0, 0, 0);

    // Illegal start while busy is ignored.
    md_start_ex = 1;
    cyc("il T", 0, 0, 0);
    md_start_ex = 0;
    cyc("il T+1", 0, 1, 0);
    md_start_ex = 1; md_op_ex = 1;
    cyc("il T+2", 0, 1, 0);
    md_start_ex = 0; md_op_ex = 0;
    for (int i = 3; i <= MUL_LAT; i++) cyc($sformatf("il T+%0d", i), 0, 1, 0);
    cyc("il done", 0, 1, 1);
    cyc("il idle", 0, 0, 0);

    // Asynchronous reset mid-multiply: outputs clear at once, no write later.
    md_start_ex = 1; hilo_r_id = 1;
    cyc("ar T", 1, 0, 0);
    md_start_ex = 0;
    cyc("ar T+1", 1, 1, 0);
    #2;
    rst_n = 0;
    #1;
    chk("arst stall_pc", stall_pc, 1'b0);
    chk("arst md_busy", md_busy, 1'b0);
    chk("arst md_done", md_done, 1'b0);
    chk("arst hilo_we", hilo_we, 1'b0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < MUL_LAT + 3; i++) cyc($sformatf("ar post%0d", i), 0, 0, 0);
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
